serial_add_ctrl: RTL
====================

# serial_add_ctrl

Bit-serial adder controller that sequences a single 1-bit adder cell to add two WIDTH-bit operands over WIDTH cycles. The cell is built from two half adders and a carry flop. Operands arrive on a valid/ready input handshake, and the (WIDTH+1)-bit result leaves on a valid/ready output handshake. The block is the area-minimal arithmetic path for slow control datapaths; it replaces a parallel adder where throughput is not critical.

## Interface
- WIDTH, 8, operand width in bits; legal range 1..32.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset; 0 forces reset state immediately.
- in_valid  in  1  operands a, b are valid.
- in_ready  out  1  block can accept operands.
- a  in  WIDTH  operand A, unsigned.
- b  in  WIDTH  operand B, unsigned.
- out_valid  out  1  sum is valid.
- out_ready  in  1  consumer accepts sum.
- sum  out  WIDTH+1  a+b; the MSB is the final carry.
- busy  out  1  high in RUN or DONE.

## Operation
- FSM states are IDLE, RUN and DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready, register a and b into shift registers, clear the carry flop, clear bit_cnt, and go to RUN.
- RUN:
  - Each cycle, the cell computes s = a_sh[0]^b_sh[0]^carry and c = majority(a_sh[0], b_sh[0], carry).
  - s is shifted into the result register from the MSB side, and carry <= c.
  - a_sh and b_sh shift right by 1, and bit_cnt increments.
  - After the cycle that processes bit WIDTH-1, go to DONE and load the final carry into sum[WIDTH].
- DONE:
  - out_valid=1.
  - sum is held stable until out_valid&&out_ready, then go to IDLE.
- Operand inputs are sampled only at acceptance. Changes on a, b or in_valid during RUN or DONE are ignored.
- The adder is unsigned and never overflows: sum = a + b exactly, in WIDTH+1 bits.
- bit_cnt is $clog2(WIDTH)+1 bits wide. The terminal count is WIDTH-1.
- With WIDTH=1, RUN lasts exactly one cycle.

## Timing
- Reset values:
  - in_ready=1, out_valid=0, busy=0, sum=0.
  - State = IDLE; carry, bit_cnt and the shift registers are 0.
- Reset mid-operation (RUN or DONE) aborts the add immediately. The partial result is discarded and outputs take their reset values asynchronously.
- Acceptance happens at rising edge k.
  - in_ready deasserts and busy asserts after edge k.
  - RUN occupies cycles k+1..k+WIDTH.
  - out_valid asserts after edge k+WIDTH, with sum valid the same cycle.
- Latency: WIDTH cycles from the acceptance edge to out_valid.
- If out_ready is already 1 when out_valid rises, the handshake completes at edge k+WIDTH+1. in_ready reasserts after that edge.
- Maximum throughput is one add per WIDTH+2 cycles.
- Output handshake rules:
  - out_valid must not drop, and sum must not change, until out_ready is sampled high.
  - Back-pressure of any length is legal.
- in_ready is combinationally equal to (state==IDLE). It does not depend on in_valid, so no combinational path exists from in_valid to in_ready.
- No combinational path from out_ready to any output.

## Test plan
- Reset then idle (WIDTH=8): hold rst=0 for 2 cycles, release -> in_ready=1, out_valid=0, busy=0, sum=9'h000.
- Basic add: a=8'h01, b=8'h01 accepted at edge k with out_ready=1 -> out_valid after edge k+8 with sum=9'h002. in_ready is high again after edge k+9.
- Carry ripple: a=8'hFF, b=8'h01 -> sum=9'h100. Then a=8'hFF, b=8'hFF -> sum=9'h1FE. Then a=8'hA5, b=8'h5A -> sum=9'h0FF.
- Back-pressure: a=8'h10, b=8'h20, out_ready=0 for 5 cycles after out_valid -> sum=9'h030 and out_valid held throughout. Raise out_ready -> one transfer, then IDLE.
- Input glitching: change a and b to 8'hFF and keep in_valid=1 during RUN -> result still equals the originally accepted operands, and no second acceptance occurs until in_ready returns.
- Reset mid-op: assert rst=0 at bit 3 of a=8'hFF, b=8'hFF -> outputs immediately return to reset values. After release, a=8'h03, b=8'h04 -> sum=9'h007 with no residual carry.

Source files
------------

// File: rtl/serial_add_ctrl.sv
// ---------------------------------------------------------------------------
// serial_add_ctrl
//
// Bit-serial unsigned adder. One 1-bit adder cell (two half adders plus a
// carry flop) is stepped over WIDTH cycles to produce a (WIDTH+1)-bit sum.
// Operands enter on a valid/ready handshake and the result leaves on a
// valid/ready handshake. Use this where area matters more than throughput.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous reset, active low
//   in_valid   operands a/b are valid
//   in_ready   block can accept operands (high only in IDLE)
//   a, b       WIDTH-bit unsigned operands, sampled only on acceptance
//   out_valid  sum is valid (high only in DONE)
//   out_ready  consumer accepts sum
//   sum        a + b; sum[WIDTH] is the final carry
//   busy       high while an add is in progress or waiting to be taken
//
// Timing: accept at edge k, RUN covers cycles k+1..k+WIDTH, out_valid
// rises after edge k+WIDTH. Best case is one add every WIDTH+2 cycles.
// ---------------------------------------------------------------------------

// Plain half adder. Two of these make the full-adder cell.
module half_adder (
    input  logic x,
    input  logic y,
    output logic s,
    output logic c
);
    assign s = x ^ y;
    assign c = x & y;
endmodule

module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   sum,
    output logic             busy
);

    // One extra bit over $clog2 keeps the counter wide enough even for
    // WIDTH=1, where $clog2 returns 0.
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_reg;
    state_t           state_next;

    logic [WIDTH-1:0] a_sh_reg;
    logic [WIDTH-1:0] b_sh_reg;
    logic [WIDTH-1:0] res_reg;      // low WIDTH bits of the sum
    logic             carry_reg;    // running carry between bit steps
    logic             cout_reg;     // final carry, becomes sum[WIDTH]
    logic [CW-1:0]    bit_cnt_reg;

    logic             accept;
    logic             out_fire;
    logic             last_bit;

    logic             ha0_s;
    logic             ha0_c;
    logic             cell_s;
    logic             ha1_c;
    logic             cell_c;
    logic [WIDTH-1:0] res_shift;

    // -----------------------------------------------------------------------
    // Adder cell: ha0 adds the two operand bits, ha1 folds in the carry.
    // The two half-adder carries can never both be 1, so OR gives the
    // majority function.
    // -----------------------------------------------------------------------
    half_adder u_ha0 (
        .x (a_sh_reg[0]),
        .y (b_sh_reg[0]),
        .s (ha0_s),
        .c (ha0_c)
    );

    half_adder u_ha1 (
        .x (ha0_s),
        .y (carry_reg),
        .s (cell_s),
        .c (ha1_c)
    );

    assign cell_c = ha0_c | ha1_c;

    // Result register fills from the MSB side; after WIDTH steps bit 0 of
    // the operands has landed in res_reg[0].
    generate
        if (WIDTH == 1) begin : g_res_w1
            assign res_shift = cell_s;
        end else begin : g_res_wn
            assign res_shift = {cell_s, res_reg[WIDTH-1:1]};
        end
    endgenerate

    // -----------------------------------------------------------------------
    // Handshake decode. All outputs come from registered state only, so
    // neither in_valid nor out_ready reaches an output combinationally.
    // -----------------------------------------------------------------------
    assign in_ready  = (state_reg == IDLE);
    assign out_valid = (state_reg == DONE);
    assign busy      = (state_reg != IDLE);
    assign sum       = {cout_reg, res_reg};

    assign accept    = in_valid && in_ready;
    assign out_fire  = out_valid && out_ready;
    assign last_bit  = (bit_cnt_reg == CW'(WIDTH - 1));

    // -----------------------------------------------------------------------
    // FSM state register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // -----------------------------------------------------------------------
    // FSM next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (last_bit) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (out_fire) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Datapath. Operands are captured only on acceptance; anything on a/b
    // afterwards is ignored. The result registers are cleared on acceptance
    // so nothing from a previous (or aborted) add can leak into sum.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_sh_reg    <= '0;
            b_sh_reg    <= '0;
            res_reg     <= '0;
            carry_reg   <= 1'b0;
            cout_reg    <= 1'b0;
            bit_cnt_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        a_sh_reg    <= a;
                        b_sh_reg    <= b;
                        res_reg     <= '0;
                        carry_reg   <= 1'b0;
                        cout_reg    <= 1'b0;
                        bit_cnt_reg <= '0;
                    end
                end
                RUN: begin
                    res_reg     <= res_shift;
                    carry_reg   <= cell_c;
                    a_sh_reg    <= a_sh_reg >> 1;
                    b_sh_reg    <= b_sh_reg >> 1;
                    bit_cnt_reg <= bit_cnt_reg + CW'(1);
                    if (last_bit) begin
                        cout_reg <= cell_c;
                    end
                end
                default: begin
                    // DONE: hold everything so sum stays stable under
                    // back-pressure.
                end
            endcase
        end
    end

endmodule
